uart_tx_fifo: RTL

//   Transmit-side front end for uart_tx. Buffers bytes written by the bus in a

---
 rtl/uart_tx_fifo.sv | 117 +++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit front end for uart_tx: byte FIFO, free-running baud enable and a
// small handshake FSM that hands one byte at a time to the serializer.
module uart_tx_fifo #(
  parameter int unsigned BUS_CLK = 10_000_000,
  parameter int unsigned BAUD    = 9600,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [7:0]                   wr_data,
  input  logic                         clr_ovf,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         baud_en,
  output logic                         send,
  output logic [7:0]                   dout,
  input  logic                         tx_busy,
  output logic                         busy
);

  localparam int unsigned DIV = BUS_CLK / BAUD;
  localparam int unsigned DW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StArmed, StSent, StWait} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] baud_cnt_q, baud_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    dout_q, dout_d;
  logic [7:0]    mem_q [DEPTH];
  logic          push, pop;

  always_comb begin
    baud_en    = (baud_cnt_q == DW'(DIV - 1));
    baud_cnt_d = baud_en ? '0 : baud_cnt_q + 1'b1;

    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    send  = (state_q == StArmed) && baud_en;
    pop   = send;
    // A pop frees a slot in the same cycle, so a write to a full FIFO still lands.
    push  = wr_en && (!full || pop);

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    overflow_d = overflow_q;
    if (wr_en && full && !pop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end

    state_d = state_q;
    dout_d  = dout_q;
    unique case (state_q)
      StIdle: begin
        // Bypass the incoming byte when empty so it arms in the same cycle it is written.
        if (!tx_busy && (!empty || wr_en)) begin
          state_d = StArmed;
          dout_d  = empty ? wr_data : mem_q[rd_ptr_q];
        end
      end
      StArmed: if (baud_en) state_d = StSent;
      StSent:  state_d = StWait;
      StWait:  if (!tx_busy) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dout_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      dout_q     <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign dout     = dout_q;
  assign busy     = !empty || (state_q != StIdle) || tx_busy;

endmodule
